// File: rtl/fifo_mq_rr_reader_if.sv
// Read-port and output-stream signals of the multi-queue FIFO reader.
interface fifo_mq_rr_reader_if #(
   parameter int unsigned nr_of_queues = 16,
   parameter int unsigned a_hi_size    = 4,
   parameter int unsigned data_width   = 36
);
   logic [0:nr_of_queues-1] fifo_empty;
   logic [0:nr_of_queues-1] read;
   logic [data_width-1:0]   q;
   logic [data_width-1:0]   dout;
   logic [a_hi_size-1:0]    dout_queue;
   logic                    dout_valid;
   logic                    dout_ready;

   // Reader side: pops the FIFO and sources the tagged output stream.
   modport master (
      input  fifo_empty, q, dout_ready,
      output read, dout, dout_queue, dout_valid
   );

   // Environment side: FIFO read port plus downstream consumer.
   modport slave (
      output fifo_empty, q, dout_ready,
      input  read, dout, dout_queue, dout_valid
   );
endinterface

// File: rtl/fifo_mq_rr_reader.sv
// Round-robin read scheduler for the multi-queue FIFO with a 4-entry
// credit-controlled output buffer tagging each word with its queue index.
module fifo_mq_rr_reader #(
   parameter int unsigned nr_of_queues = 16,
   parameter int unsigned a_hi_size    = 4,
   parameter int unsigned data_width   = 36
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_mq_rr_reader_if.master  bus
);

   localparam int unsigned OCC_W     = 3;
   localparam int unsigned MAX_CREDIT = 3;

   typedef struct packed {
      logic [a_hi_size-1:0]  tag;
      logic [data_width-1:0] data;
   } entry_t;

   logic [0:nr_of_queues-1] read_q, read_d;
   logic [0:nr_of_queues-1] s2_oh_q, s2_oh_d;
   logic                    s1_valid_q, s1_valid_d;
   logic                    s2_valid_q, s2_valid_d;
   logic [a_hi_size-1:0]    s1_tag_q, s1_tag_d;
   logic [a_hi_size-1:0]    s2_tag_q, s2_tag_d;
   logic [a_hi_size-1:0]    last_q, last_d;
   entry_t                  buf_q [4];
   entry_t                  buf_d [4];
   logic [OCC_W-1:0]        occ_q, occ_d;
   logic                    dout_valid_q, dout_valid_d;

   logic [0:nr_of_queues-1] eligible_c;
   logic                    credit_ok_c;
   logic                    grant_c;
   logic [a_hi_size-1:0]    grant_idx_c;
   logic                    pop_c;
   logic [OCC_W-1:0]        wr_idx_c;

   // A queue strobed this cycle (read) or last cycle (s2) may still show a
   // stale non-empty flag, so it sits out two cycles after each grant.
   always_comb begin
      eligible_c = ~bus.fifo_empty & ~read_q & ~s2_oh_q;
   end

   // Credit check and round-robin search starting after the last grant.
   always_comb begin
      int unsigned idx;
      grant_c     = 1'b0;
      grant_idx_c = '0;
      idx         = 0;
      credit_ok_c = (occ_q + OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q)) <= OCC_W'(MAX_CREDIT);
      for (int unsigned k = 1; k <= nr_of_queues; k++) begin
         idx = (32'(last_q) + k) % nr_of_queues;
         if (credit_ok_c && !grant_c && eligible_c[a_hi_size'(idx)]) begin
            grant_c     = 1'b1;
            grant_idx_c = a_hi_size'(idx);
         end
      end
   end

   // Read strobe and tag pipeline next state.
   always_comb begin
      read_d = '0;
      if (grant_c) begin
         read_d[grant_idx_c] = 1'b1;
      end
      s1_valid_d = grant_c;
      s1_tag_d   = grant_idx_c;
      s2_valid_d = s1_valid_q;
      s2_tag_d   = s1_tag_q;
      s2_oh_d    = read_q;
      last_d     = grant_c ? grant_idx_c : last_q;
   end

   // Shift-register output buffer: head always in entry 0.
   always_comb begin
      buf_d    = buf_q;
      pop_c    = dout_valid_q && bus.dout_ready;
      wr_idx_c = occ_q;
      if (pop_c) begin
         buf_d[0] = buf_q[1];
         buf_d[1] = buf_q[2];
         buf_d[2] = buf_q[3];
         wr_idx_c = occ_q - OCC_W'(1);
      end
      if (s2_valid_q) begin
         buf_d[wr_idx_c[1:0]].tag  = s2_tag_q;
         buf_d[wr_idx_c[1:0]].data = bus.q;
      end
      occ_d        = occ_q + OCC_W'(s2_valid_q) - OCC_W'(pop_c);
      dout_valid_d = (occ_d != '0);
   end

   // State registers; reset discards in-flight reads and buffered words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_q       <= '0;
         s2_oh_q      <= '0;
         s1_valid_q   <= 1'b0;
         s2_valid_q   <= 1'b0;
         s1_tag_q     <= '0;
         s2_tag_q     <= '0;
         last_q       <= a_hi_size'(nr_of_queues - 1);
         buf_q        <= '{default: '0};
         occ_q        <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         read_q       <= read_d;
         s2_oh_q      <= s2_oh_d;
         s1_valid_q   <= s1_valid_d;
         s2_valid_q   <= s2_valid_d;
         s1_tag_q     <= s1_tag_d;
         s2_tag_q     <= s2_tag_d;
         last_q       <= last_d;
         buf_q        <= buf_d;
         occ_q        <= occ_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign bus.read       = read_q;
   assign bus.dout       = buf_q[0].data;
   assign bus.dout_queue = buf_q[0].tag;
   assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fifo_mq_rr_reader.sv
// Scoreboard bench for the round-robin multi-queue FIFO reader.
module tb_fifo_mq_rr_reader;

   localparam int unsigned NQ = 16;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 36;

   typedef struct {
      logic [AW-1:0] tag;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   fifo_mq_rr_reader_if #(.nr_of_queues(NQ), .a_hi_size(AW), .data_width(DW)) bus ();

   fifo_mq_rr_reader #(.nr_of_queues(NQ), .a_hi_size(AW), .data_width(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   strobes[$];
   int   strobe_cyc[$];
   bit   dv_hist[$];
   bit   pend_v;
   exp_t pend;
   bit   fixed_a5;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_rr[3] = '{0, 5, 15};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_word();
      return DW'({$urandom(), $urandom()});
   endfunction

   // Monitor: models the FIFO RAM (q one cycle after the strobe), fills the
   // scoreboard in grant order and checks every accepted output word.
   always @(negedge clk) begin : mon
      int idx;
      exp_t e;
      if (rst) begin
         sb.delete();
         pend_v = 1'b0;
         bus.q  = rnd_word();
      end else begin
         if (pend_v) begin
            bus.q = pend.data;
            sb.push_back(pend);
            pend_v = 1'b0;
         end else begin
            bus.q = rnd_word();
         end
         if (bus.read != '0) begin
            check("read_onehot", 64'($onehot(bus.read)), 64'd1);
            idx = -1;
            for (int i = 0; i < int'(NQ); i++) begin
               if (bus.read[i] && idx < 0) idx = i;
            end
            pend_v    = 1'b1;
            pend.tag  = AW'(idx);
            pend.data = fixed_a5 ? DW'(36'hA5) : rnd_word();
            strobes.push_back(idx);
            strobe_cyc.push_back(dv_hist.size());
         end
         if (bus.dout_valid && bus.dout_ready) begin
            check("sb_word_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("dout_queue", 64'(bus.dout_queue), 64'(e.tag));
               check("dout", 64'(bus.dout), 64'(e.data));
            end
         end
         dv_hist.push_back(bus.dout_valid);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ne(input int a, input int b, input int c);
      logic [0:NQ-1] fe;
      fe = '1;
      if (a >= 0) fe[a] = 1'b0;
      if (b >= 0) fe[b] = 1'b0;
      if (c >= 0) fe[c] = 1'b0;
      bus.fifo_empty = fe;
   endtask

   task automatic clear_logs();
      strobes.delete();
      strobe_cyc.delete();
      dv_hist.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic drain();
      set_ne(-1, -1, -1);
      bus.dout_ready = 1'b1;
      tick(12);
      check("drain_sb_empty", 64'(sb.size()), 64'd0);
      check("drain_idle", 64'(bus.dout_valid), 64'd0);
   endtask

   task automatic wait_strobe(input int max);
      for (int i = 0; i < max && strobes.size() == 0; i++) tick(1);
      check("strobe_seen", 64'(strobes.size() > 0), 64'd1);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_read"}, 64'(bus.read), 64'd0);
      check({pfx, "_valid"}, 64'(bus.dout_valid), 64'd0);
      check({pfx, "_dout"}, 64'(bus.dout), 64'd0);
      check({pfx, "_queue"}, 64'(bus.dout_queue), 64'd0);
   endtask

   initial begin
      int ones;
      rst            = 1'b1;
      fixed_a5       = 1'b0;
      bus.fifo_empty = NQ'($urandom());
      bus.dout_ready = 1'($urandom());
      tick(3);
      check_reset_outputs("reset");

      // First grant after reset goes to the lowest non-empty queue.
      set_ne(6, 9, -1);
      bus.dout_ready = 1'b1;
      clear_logs();
      rst = 1'b0;
      wait_strobe(10);
      if (strobes.size() > 0) check("first_grant", 64'(strobes[0]), 64'd6);
      drain();

      // Single queue: one strobe per 3 cycles, valid 2 cycles after strobe.
      clear_logs();
      fixed_a5 = 1'b1;
      set_ne(3, -1, -1);
      tick(16);
      drain();
      fixed_a5 = 1'b0;
      check("sq_count", 64'(strobes.size() >= 4), 64'd1);
      for (int j = 0; j < strobes.size(); j++) begin
         check("sq_tag", 64'(strobes[j]), 64'd3);
         if (j > 0) check("sq_gap", 64'(strobe_cyc[j] - strobe_cyc[j-1]), 64'd3);
         if (strobe_cyc[j] + 2 < dv_hist.size()) begin
            check("sq_dv_lat1", 64'(dv_hist[strobe_cyc[j] + 1]), 64'd0);
            check("sq_dv_lat2", 64'(dv_hist[strobe_cyc[j] + 2]), 64'd1);
         end
      end

      // Round robin across queues 0, 5, 15 at one word per cycle.
      do_reset();
      clear_logs();
      set_ne(0, 5, 15);
      tick(16);
      drain();
      check("rr_count", 64'(strobes.size() >= 12), 64'd1);
      for (int j = 0; j < 12 && j < strobes.size(); j++) begin
         check("rr_order", 64'(strobes[j]), 64'(exp_rr[j % 3]));
         if (j > 0) check("rr_gap", 64'(strobe_cyc[j] - strobe_cyc[j-1]), 64'd1);
      end
      if (strobes.size() > 0) begin
         for (int s = strobe_cyc[0] + 2; s < strobe_cyc[0] + 14 && s < dv_hist.size(); s++)
            check("rr_dv_cont", 64'(dv_hist[s]), 64'd1);
      end

      // Backpressure: exactly four strobes, then release and drain in order.
      do_reset();
      clear_logs();
      bus.dout_ready = 1'b0;
      set_ne(1, 2, -1);
      tick(8);
      check("bp_strobes", 64'(strobes.size()), 64'd4);
      check("bp_read_idle", 64'(bus.read), 64'd0);
      check("bp_valid", 64'(bus.dout_valid), 64'd1);
      for (int j = 0; j < 4 && j < strobes.size(); j++)
         check("bp_order", 64'(strobes[j]), (j % 2 == 0) ? 64'd1 : 64'd2);
      bus.dout_ready = 1'b1;
      tick(10);
      check("bp_resume", 64'(strobes.size() > 4), 64'd1);
      drain();

      // All empty: nothing is issued and nothing appears.
      clear_logs();
      set_ne(-1, -1, -1);
      tick(20);
      check("ae_strobes", 64'(strobes.size()), 64'd0);
      ones = 0;
      foreach (dv_hist[i]) ones += int'(dv_hist[i]);
      check("ae_valid", 64'(ones), 64'd0);

      // Reset with two buffered words and a strobe in flight.
      clear_logs();
      bus.dout_ready = 1'b0;
      set_ne(0, 1, -1);
      tick(4);
      check("rm_pre_valid", 64'(bus.dout_valid), 64'd1);
      check("rm_pre_inflight", 64'(bus.read != '0), 64'd1);
      rst = 1'b1;
      #1;
      check_reset_outputs("rm_async");
      set_ne(0, 2, -1);
      bus.dout_ready = 1'b1;
      tick(2);
      clear_logs();
      rst = 1'b0;
      wait_strobe(10);
      if (strobes.size() > 0) check("rm_restart_q0", 64'(strobes[0]), 64'd0);
      tick(8);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
